// File: rtl/aes_pkg.sv
// Shared AES constants: byte S-boxes, widths and the backward Rcon step.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Backward Rcon step: inverse of xtime in GF(2^8) mod 0x11B.
    // An odd Rcon came from a value whose top bit overflowed into 0x1B.
    function automatic logic [7:0] rcon_prev(input logic [7:0] rcon);
        logic [7:0] t;
        if (rcon[0]) begin
            t = rcon ^ 8'h1b;
            return (t >> 1) | 8'h80;
        end
        return rcon >> 1;
    endfunction

endpackage

// File: rtl/inv_sbox_byte.sv
// Combinational single-byte inverse S-box lookup.
module inv_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_sbox_key_stage.sv
// Decryption-side round stage: InvSubBytes on the state plus one backward
// step of the AES-128 key schedule, captured in a single enabled register rank.
module inv_sbox_key_stage
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   Rcon_in,
    input  logic         empty_in,
    output logic [127:0] state_out,
    output logic [127:0] key_out,
    output logic [7:0]   Rcon_out,
    output logic         empty
);

    localparam int NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    // Byte lanes; lane ordering is irrelevant since each byte maps independently.
    logic [NUM_BYTES-1:0][AES_BYTE_W-1:0] in_bytes;
    logic [NUM_BYTES-1:0][AES_BYTE_W-1:0] inv_bytes;

    assign in_bytes = state_in;

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_inv_sbox
        inv_sbox_byte u_inv_sbox_byte (
            .in_byte  (in_bytes[i]),
            .out_byte (inv_bytes[i])
        );
    end

    // Key words: w0 sits in the most significant 32 bits.
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_p3;
    logic [31:0] sub_rot_p3;

    assign k0 = key_in[127:96];
    assign k1 = key_in[95:64];
    assign k2 = key_in[63:32];
    assign k3 = key_in[31:0];

    // Undo the forward chaining: each later word was its predecessor XOR the new word.
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    // SubWord through the forward S-box, one lookup per byte.
    always_comb begin
        sub_rot_p3 = '0;
        for (int j = 0; j < 4; j++) begin
            sub_rot_p3[8*j +: 8] = SBOX[rot_p3[8*j +: 8]];
        end
    end

    assign p0 = k0 ^ sub_rot_p3 ^ {Rcon_in, 24'h000000};

    logic [127:0] state_out_d, state_out_q;
    logic [127:0] key_out_d,   key_out_q;
    logic [7:0]   rcon_out_d,  rcon_out_q;
    logic         empty_d,     empty_q;

    // Data registers load only for real blocks; bubbles keep the last result.
    always_comb begin
        state_out_d = state_out_q;
        key_out_d   = key_out_q;
        rcon_out_d  = rcon_out_q;
        empty_d     = empty_in;
        if (!empty_in) begin
            state_out_d = inv_bytes;
            key_out_d   = {p0, p1, p2, p3};
            rcon_out_d  = rcon_prev(Rcon_in);
        end
    end

    // Single register rank; reset wins over everything and marks the output as a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_out_q <= '0;
            key_out_q   <= '0;
            rcon_out_q  <= '0;
            empty_q     <= 1'b1;
        end else begin
            state_out_q <= state_out_d;
            key_out_q   <= key_out_d;
            rcon_out_q  <= rcon_out_d;
            empty_q     <= empty_d;
        end
    end

    assign state_out = state_out_q;
    assign key_out   = key_out_q;
    assign Rcon_out  = rcon_out_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_inv_sbox_key_stage.sv
// Scoreboard bench for inv_sbox_key_stage: directed vectors with hand-computed results.
module tb_inv_sbox_key_stage;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic [7:0]   Rcon_in;
    logic         empty_in;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [7:0]   Rcon_out;
    logic         empty;

    inv_sbox_key_stage dut (
        .clock     (clock),
        .reset     (reset),
        .state_in  (state_in),
        .key_in    (key_in),
        .Rcon_in   (Rcon_in),
        .empty_in  (empty_in),
        .state_out (state_out),
        .key_out   (key_out),
        .Rcon_out  (Rcon_out),
        .empty     (empty)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [127:0] s;
        logic [127:0] k;
        logic [7:0]   r;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Input vectors and their hand-computed expected results
    localparam logic [127:0] S1  = {4{32'h0001637c}};
    localparam logic [127:0] S1X = {4{32'h52090001}};
    localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1X = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] S2  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] S2X = 128'h7d99c927fe62f99702d3ed866694e352;
    localparam logic [127:0] K2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2X = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] S3  = {16{8'h52}};
    localparam logic [127:0] S3X = {16{8'h48}};
    localparam logic [127:0] K3X = 128'h78636363000000000000000000000000;
    localparam logic [127:0] S4  = '0;
    localparam logic [127:0] S4X = {16{8'h52}};
    localparam logic [127:0] K4X = 128'he3636363000000000000000000000000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one input set across one rising edge; queue the expected result for real blocks.
    task automatic drive(input logic [127:0] s, input logic [127:0] k, input logic [7:0] r,
                         input logic e, input logic rst, input logic push, input exp_t ex);
        state_in = s;
        key_in   = k;
        Rcon_in  = r;
        empty_in = e;
        reset    = rst;
        @(posedge clock);
        if (push) q.push_back(ex);
        #1;
    endtask

    // Monitor: every non-bubble output must match the oldest queued expectation.
    always @(negedge clock) begin
        if (empty === 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got state %h with empty scoreboard", state_out);
            end else begin
                exp_t ex;
                ex = q.pop_front();
                chk("sb_state", state_out, ex.s);
                chk("sb_key", key_out, ex.k);
                chk("sb_rcon", {120'h0, Rcon_out}, {120'h0, ex.r});
            end
        end
    end

    initial begin
        exp_t e1, e2, e3, e4, none;
        int   waited;
        e1   = '{s: S1X, k: K1X, r: 8'h8d};
        e2   = '{s: S2X, k: K2X, r: 8'h1b};
        e3   = '{s: S3X, k: K3X, r: 8'h80};
        e4   = '{s: S4X, k: K4X, r: 8'h40};
        none = '0;

        // Reset held for two edges with live-looking inputs
        drive({16{8'ha5}}, K2, 8'h77, 1'b0, 1'b1, 1'b0, none);
        drive({16{8'h3c}}, K1, 8'h01, 1'b0, 1'b1, 1'b0, none);
        chk("rst_empty", {127'h0, empty}, 128'h1);
        chk("rst_state", state_out, '0);
        chk("rst_key", key_out, '0);
        chk("rst_rcon", {120'h0, Rcon_out}, '0);

        // Back-to-back valid blocks
        drive(S1, K1, 8'h01, 1'b0, 1'b0, 1'b1, e1);
        chk("first_empty", {127'h0, empty}, '0);
        drive(S2, K2, 8'h36, 1'b0, 1'b0, 1'b1, e2);
        drive(S3, '0, 8'h1b, 1'b0, 1'b0, 1'b1, e3);
        drive(S4, '0, 8'h80, 1'b0, 1'b0, 1'b1, e4);

        // Bubble between two valid blocks: outputs hold through the bubble
        drive(S1, K1, 8'h01, 1'b0, 1'b0, 1'b1, e1);
        chk("bub_empty0", {127'h0, empty}, '0);
        drive(S2, K2, 8'h36, 1'b1, 1'b0, 1'b0, none);
        chk("bub_empty1", {127'h0, empty}, 128'h1);
        chk("bub_hold_state", state_out, S1X);
        chk("bub_hold_key", key_out, K1X);
        chk("bub_hold_rcon", {120'h0, Rcon_out}, {120'h0, 8'h8d});
        drive(S2, K2, 8'h36, 1'b0, 1'b0, 1'b1, e2);
        chk("bub_empty2", {127'h0, empty}, '0);

        // Mid-stream reset discards the second block
        drive(S3, '0, 8'h1b, 1'b0, 1'b0, 1'b1, e3);
        drive(S1, K1, 8'h01, 1'b0, 1'b1, 1'b0, none);
        chk("mid_rst_empty", {127'h0, empty}, 128'h1);
        chk("mid_rst_state", state_out, '0);
        chk("mid_rst_key", key_out, '0);
        chk("mid_rst_rcon", {120'h0, Rcon_out}, '0);
        drive(S4, '0, 8'h80, 1'b0, 1'b0, 1'b1, e4);
        chk("resume_empty", {127'h0, empty}, '0);

        // Drain with bubbles, bounded
        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            drive(S2, K2, 8'h36, 1'b1, 1'b0, 1'b0, none);
            waited++;
        end
        drive(S2, K2, 8'h36, 1'b1, 1'b0, 1'b0, none);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
